rate_limiter: RTL and testbench
===============================

// Module: rate_limiter
//
// PURPOSE
// - Slew-rate limiter for an unsigned sample stream.
// - Each clock, data_out steps toward data_in by at most step_size LSBs.
// - Sits between a setpoint source and an actuator/DAC path to bound the per-cycle change.
// - Purely synchronous datapath: one clock domain, no handshake.
//
// PARAMETERS
// - DATA_W  6  width of data_in/data_out (unsigned)
// - STEP_W  3  width of step_size (unsigned); requires STEP_W <= DATA_W
//
// PORTS
// - clk        in   1        rising-edge clock
// - reset      in   1        asynchronous, active-low reset (0 = reset asserted)
// - data_in    in   DATA_W   target value, unsigned, sampled every rising edge
// - step_size  in   STEP_W   max |change| of data_out per clock, unsigned, sampled every edge
// - data_out   out  DATA_W   rate-limited output, registered
// - limiting   out  1        only with RATE_LIMITER_STATUS_EN (see CONFIGURATION)
//
// BEHAVIOUR
// - Reset (reset==0): data_out=0 (and limiting=0) immediately, independent of clk; held while low.
// - First update is on the first rising edge after reset goes high; no extra recovery cycle.
// - Each rising edge, with diff = data_in - data_out computed in DATA_W+1 bits:
//   - data_in > data_out and diff > step_size: data_out <= data_out + step_size
//   - data_in < data_out and (data_out - data_in) > step_size: data_out <= data_out - step_size
//   - |diff| <= step_size (includes equal): data_out <= data_in (exact landing, no overshoot)
// - Latency: data_out reflects the inputs sampled at the previous edge. There is no combinational path from inputs to data_out.
// - step_size==0: data_out holds its value; the output never reaches data_in unless it is already equal.
// - Arithmetic: step_size is zero-extended to DATA_W. Comparisons and add/sub use DATA_W+1 bits.
// - Wrap-around: none. The result always lies between the old data_out and data_in, so it stays in [0, 2^DATA_W-1].
// - data_in or step_size changing mid-slew: the new values take effect at the next edge; the slew direction can reverse in one cycle.
// - Reset asserted mid-slew: data_out clears to 0 asynchronously. After release, slewing restarts from 0.
//
// CONFIGURATION
// - Macro RATE_LIMITER_STATUS_EN
// - Defined:
//   - adds output port `limiting`.
//   - limiting is registered and updates on the same edge as data_out.
//   - limiting=1 when that update was clipped by step_size (|diff| > step_size), else 0.
//   - reset value 0.
// - Undefined:
//   - port `limiting` and its logic are absent.
//   - data_out behaviour is identical either way.
//
// TESTING
// - Reset: hold reset=0 with data_in=20, step=7, toggling clk -> data_out=0. Assert reset between edges -> data_out drops to 0 before the next edge.
// - Small step-up: from 0, data_in=5, step=7 -> data_out=5 after 1 edge; limiting=0.
// - Slew up: from 5, data_in=32, step=7 -> 12,19,26,32, then holds 32; limiting=1,1,1,0.
// - Slew down: from 32, data_in=15, step=7 -> 25,18,15, then holds 15 for 8+ edges (equal case).
// - Full scale: from 63, data_in=0, step=7 -> 56,49,...,7,0; no underflow. With step=0 the output holds.
// - Mid-slew reset: during the 5->32 slew, reset=0 -> data_out=0. Release -> 7,14,21,28,32.

Source files
------------

// File: rtl/rate_limiter.sv
// Slew-rate limiter: data_out steps toward data_in by at most step_size per clock.
// Optional RATE_LIMITER_STATUS_EN adds a registered `limiting` clip flag.
module rate_limiter #(
   parameter int DATA_W = 6,
   parameter int STEP_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic [STEP_W-1:0] step_size,
   output logic [DATA_W-1:0] data_out
`ifdef RATE_LIMITER_STATUS_EN
   ,
   output logic              limiting
`endif
);

   logic [DATA_W-1:0] r_out;
   logic [DATA_W-1:0] w_step_n;
   logic [DATA_W:0]   w_in;
   logic [DATA_W:0]   w_out;
   logic [DATA_W:0]   w_step;
   logic [DATA_W:0]   w_up;
   logic [DATA_W:0]   w_dn;
   logic              w_go_up;
   logic              w_go_dn;
   logic [DATA_W-1:0] w_next;

   assign w_step_n = {{(DATA_W-STEP_W){1'b0}}, step_size};
   assign w_in     = {1'b0, data_in};
   assign w_out    = {1'b0, r_out};
   assign w_step   = {1'b0, w_step_n};
   assign w_up     = w_in - w_out;
   assign w_dn     = w_out - w_in;

   // Clip only when the gap exceeds the step; otherwise land exactly.
   assign w_go_up  = (w_in > w_out) && (w_up > w_step);
   assign w_go_dn  = (w_in < w_out) && (w_dn > w_step);

   always_comb begin
      w_next = data_in;
      if (w_go_up)
         w_next = r_out + w_step_n;
      else if (w_go_dn)
         w_next = r_out - w_step_n;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_out <= '0;
      else
         r_out <= w_next;
   end

   assign data_out = r_out;

`ifdef RATE_LIMITER_STATUS_EN
   logic r_lim;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_lim <= 1'b0;
      else
         r_lim <= w_go_up | w_go_dn;
   end

   assign limiting = r_lim;
`endif

endmodule

// File: tb/tb_rate_limiter.sv
// Scoreboard bench for rate_limiter: driver pushes model results, monitor
// pops and compares one cycle later. Works with or without RATE_LIMITER_STATUS_EN.
module tb_rate_limiter;

   localparam int DATA_W = 6;
   localparam int STEP_W = 3;

   typedef struct {
      int d;
      bit lim;
      bit is_rst;
   } exp_t;

   logic              clk;
   logic              reset;
   logic [DATA_W-1:0] data_in;
   logic [STEP_W-1:0] step_size;
   logic [DATA_W-1:0] data_out;
`ifdef RATE_LIMITER_STATUS_EN
   logic              limiting;
`endif

   int   n_tests;
   int   n_fail;
   int   model_out;
   exp_t q[$];

   rate_limiter #(
      .DATA_W(DATA_W),
      .STEP_W(STEP_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .data_in  (data_in),
      .step_size(step_size),
      .data_out (data_out)
`ifdef RATE_LIMITER_STATUS_EN
      ,
      .limiting (limiting)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every edge the DUT presents a new sample.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.is_rst ? "data_out_rst" : "data_out", int'(data_out), e.d);
`ifdef RATE_LIMITER_STATUS_EN
            chk("limiting", int'(limiting), int'(e.lim));
`endif
         end
      end
   end

   // Behavioural rule: land on target if within step, else move by step.
   task automatic cyc(input int din, input int st, input bit rstv);
      exp_t e;
      int   gap;
      @(negedge clk);
      data_in   = DATA_W'(din);
      step_size = STEP_W'(st);
      reset     = rstv;
      e.is_rst  = !rstv;
      e.lim     = 1'b0;
      if (!rstv) begin
         model_out = 0;
      end else begin
         gap = din - model_out;
         if (gap > st) begin
            model_out = model_out + st;
            e.lim = 1'b1;
         end else if (-gap > st) begin
            model_out = model_out - st;
            e.lim = 1'b1;
         end else begin
            model_out = din;
         end
      end
      e.d = model_out;
      q.push_back(e);
   endtask

   task automatic async_rst();
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_data_out", int'(data_out), 0);
`ifdef RATE_LIMITER_STATUS_EN
      chk("async_rst_limiting", int'(limiting), 0);
`endif
      model_out = 0;
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      model_out = 0;
      reset     = 1'b0;
      data_in   = 6'd20;
      step_size = 3'd7;
      #1;
      chk("reset_at_start", int'(data_out), 0);

      for (int i = 0; i < 3; i++) cyc(20, 7, 1'b0);
      cyc(5, 7, 1'b1);
      for (int i = 0; i < 5; i++) cyc(32, 7, 1'b1);
      for (int i = 0; i < 11; i++) cyc(15, 7, 1'b1);
      for (int i = 0; i < 9; i++) cyc(63, 7, 1'b1);
      for (int i = 0; i < 11; i++) cyc(0, 7, 1'b1);
      for (int i = 0; i < 4; i++) cyc(40, 0, 1'b1);
      cyc(5, 7, 1'b1);
      cyc(32, 7, 1'b1);
      cyc(32, 7, 1'b1);
      async_rst();
      cyc(32, 7, 1'b0);
      for (int i = 0; i < 6; i++) cyc(32, 7, 1'b1);
      cyc(63, 7, 1'b1);
      cyc(0, 7, 1'b1);

      for (int i = 0; i < 400; i++) begin
         cyc(int'($urandom_range(0, 63)),
             int'($urandom_range(0, 7)),
             ($urandom_range(0, 39) != 0));
      end
      for (int i = 0; i < 20; i++) begin
         cyc((i % 2 == 0) ? 63 : 0, int'($urandom_range(0, 7)), 1'b1);
      end

      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish by 200000");
      $fatal(1, "timeout");
   end

endmodule
